// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores, a two-state drain engine towards
// the memory controller, and a combinational store-to-load forwarding lookup.
module store_buffer #(
    parameter int BUFFER_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        push_request_i,
    input  logic [65:0] packet_i,
    output logic        full_o,
    output logic        empty_o,
    output logic        store_request_o,
    output logic [31:0] store_data_o,
    output logic [31:0] store_address_o,
    output logic [1:0]  store_width_o,
    input  logic        store_done_i,
    input  logic [31:0] fwd_address_i,
    output logic        fwd_hit_o,
    output logic [31:0] fwd_data_o,
    output logic        fwd_conflict_o
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] REQUEST = 1'b1;

    logic [31:0] mem_data_q  [BUFFER_DEPTH];
    logic [31:0] mem_addr_q  [BUFFER_DEPTH];
    logic [1:0]  mem_width_q [BUFFER_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic             store_req_q, store_req_d;
    logic [31:0]      store_data_q, store_data_d;
    logic [31:0]      store_addr_q, store_addr_d;
    logic [1:0]       store_width_q, store_width_d;

    logic             push_accept;
    logic             pop;
    logic [PTR_W-1:0] fwd_idx;

    assign full_o          = (count_q == FULL_CNT);
    assign empty_o         = (count_q == '0);
    assign store_request_o = store_req_q;
    assign store_data_o    = store_data_q;
    assign store_address_o = store_addr_q;
    assign store_width_o   = store_width_q;

    // A full buffer refuses pushes even when the head retires on the same edge.
    always_comb begin
        push_accept = push_request_i && !full_o;
        pop         = (state_q == REQUEST) && store_done_i;
        wr_ptr_d    = push_accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push_accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_accept && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        store_req_d   = store_req_q;
        store_data_d  = store_data_q;
        store_addr_d  = store_addr_q;
        store_width_d = store_width_q;
        case (state_q)
            IDLE: begin
                if (!empty_o) begin
                    store_data_d  = mem_data_q[rd_ptr_q];
                    store_addr_d  = mem_addr_q[rd_ptr_q];
                    store_width_d = mem_width_q[rd_ptr_q];
                    store_req_d   = 1'b1;
                    state_d       = REQUEST;
                end
            end
            default: begin
                if (store_done_i) begin
                    store_req_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    // Walk oldest to youngest so the youngest overlapping entry has the final say.
    always_comb begin
        fwd_hit_o      = 1'b0;
        fwd_data_o     = '0;
        fwd_conflict_o = 1'b0;
        fwd_idx        = rd_ptr_q;
        for (int i = 0; i < BUFFER_DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (mem_addr_q[fwd_idx][31:2] == fwd_address_i[31:2])) begin
                if ((mem_width_q[fwd_idx] == WIDTH_WORD) && (mem_addr_q[fwd_idx] == fwd_address_i)) begin
                    fwd_hit_o      = 1'b1;
                    fwd_data_o     = mem_data_q[fwd_idx];
                    fwd_conflict_o = 1'b0;
                end else begin
                    fwd_hit_o      = 1'b0;
                    fwd_data_o     = '0;
                    fwd_conflict_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            store_req_q   <= 1'b0;
            store_data_q  <= '0;
            store_addr_q  <= '0;
            store_width_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            store_req_q   <= store_req_d;
            store_data_q  <= store_data_d;
            store_addr_q  <= store_addr_d;
            store_width_q <= store_width_d;
        end
    end

    // Entry storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_accept) begin
            mem_data_q[wr_ptr_q]  <= packet_i[65:34];
            mem_addr_q[wr_ptr_q]  <= packet_i[33:2];
            mem_width_q[wr_ptr_q] <= packet_i[1:0];
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the buffer.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        push_request_i = 1'b0;
    logic [65:0] packet_i = '0;
    logic        full_o;
    logic        empty_o;
    logic        store_request_o;
    logic [31:0] store_data_o;
    logic [31:0] store_address_o;
    logic [1:0]  store_width_o;
    logic        store_done_i = 1'b0;
    logic [31:0] fwd_address_i = '0;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic        fwd_conflict_o;

    int total = 0;
    int bad = 0;

    logic [65:0] mq[$];
    bit          m_req = 1'b0;
    logic [65:0] m_cur = '0;

    logic [31:0] addr_set [5] = '{32'h100, 32'h101, 32'h102, 32'h104, 32'h200};
    logic [31:0] fwd_set  [5] = '{32'h100, 32'h101, 32'h104, 32'h200, 32'h300};

    store_buffer #(.BUFFER_DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .push_request_i (push_request_i),
        .packet_i       (packet_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .store_request_o(store_request_o),
        .store_data_o   (store_data_o),
        .store_address_o(store_address_o),
        .store_width_o  (store_width_o),
        .store_done_i   (store_done_i),
        .fwd_address_i  (fwd_address_i),
        .fwd_hit_o      (fwd_hit_o),
        .fwd_data_o     (fwd_data_o),
        .fwd_conflict_o (fwd_conflict_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [65:0] mk(input logic [31:0] d, input logic [31:0] a, input logic [1:0] w);
        return {d, a, w};
    endfunction

    // Reference forwarding: scan from the youngest pending store, first overlap decides.
    function automatic void fwd_ref(input logic [31:0] a, output bit hit, output logic [31:0] data,
                                    output bit conf);
        bit found;
        logic [65:0] e;
        hit = 1'b0;
        data = '0;
        conf = 1'b0;
        found = 1'b0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            e = mq[i];
            if (!found && (e[33:4] == a[31:2])) begin
                found = 1'b1;
                if ((e[1:0] == 2'd2) && (e[33:2] == a)) begin
                    hit = 1'b1;
                    data = e[65:34];
                end else begin
                    conf = 1'b1;
                end
            end
        end
    endfunction

    // One clock: drive inputs, advance the reference model, land at posedge+1.
    task automatic step(input bit push, input logic [65:0] pkt, input bit done);
        bit accept;
        logic [65:0] tmp;
        push_request_i = push;
        packet_i = pkt;
        store_done_i = done;
        accept = push && (mq.size() < DEPTH);
        if (m_req && done) begin
            tmp = mq.pop_front();
            m_req = 1'b0;
        end else if (!m_req && (mq.size() != 0)) begin
            m_req = 1'b1;
            m_cur = mq[0];
        end
        if (accept) mq.push_back(pkt);
        @(posedge clk_i);
        #1;
        push_request_i = 1'b0;
        store_done_i = 1'b0;
    endtask

    task automatic wait_req(input string name);
        for (int n = 0; n < 20 && !store_request_o; n++) step(1'b0, '0, 1'b0);
        total++;
        if (store_request_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s wait_req: store_request_o=%b required 1 within 20 cycles", name, store_request_o);
        end
    endtask

    task automatic drain_all();
        repeat (3 * DEPTH + 2) step(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        fwd_address_i = 32'h1000;
        #2;
        total++; if (full_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got %b want 0", full_o); end
        total++; if (empty_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got %b want 1", empty_o); end
        total++; if (store_request_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got %b want 0", store_request_o); end
        total++; if ({store_data_o, store_address_o, store_width_o} !== 66'h0) begin
            bad++; $display("[TB] FAIL reset_payload got %h/%h/%h want 0", store_data_o, store_address_o, store_width_o);
        end
        total++; if ({fwd_hit_o, fwd_conflict_o} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_fwd got hit=%b conf=%b want 0/0", fwd_hit_o, fwd_conflict_o);
        end
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
    endtask

    task automatic test_single_store();
        step(1'b1, mk(32'hDEADBEEF, 32'h1000, 2'd2), 1'b0);
        total++; if (store_request_o !== 1'b0) begin bad++; $display("[TB] FAIL single_req_early got %b want 0", store_request_o); end
        step(1'b0, '0, 1'b0);
        total++; if (store_request_o !== 1'b1) begin bad++; $display("[TB] FAIL single_req got %b want 1", store_request_o); end
        total++; if (store_address_o !== 32'h1000) begin bad++; $display("[TB] FAIL single_addr got %h want 00001000", store_address_o); end
        total++; if (store_data_o !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_data got %h want deadbeef", store_data_o); end
        total++; if (store_width_o !== 2'd2) begin bad++; $display("[TB] FAIL single_width got %0d want 2", store_width_o); end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        total++; if (store_request_o !== 1'b1) begin bad++; $display("[TB] FAIL single_hold got %b want 1", store_request_o); end
        step(1'b0, '0, 1'b1);
        total++; if (empty_o !== 1'b1) begin bad++; $display("[TB] FAIL single_empty got %b want 1", empty_o); end
        total++; if (store_request_o !== 1'b0) begin bad++; $display("[TB] FAIL single_done got %b want 0", store_request_o); end
    endtask

    task automatic test_full_order();
        for (int k = 1; k <= 4; k++) step(1'b1, mk(32'h100 + k, 32'h3000 + 4 * k, 2'd2), 1'b0);
        total++; if (full_o !== 1'b1) begin bad++; $display("[TB] FAIL full_set got %b want 1", full_o); end
        step(1'b1, mk(32'h105, 32'h3014, 2'd2), 1'b0);
        total++; if (full_o !== 1'b1) begin bad++; $display("[TB] FAIL full_drop got %b want 1", full_o); end
        for (int k = 1; k <= 4; k++) begin
            wait_req("full_order");
            total++; if (store_address_o !== 32'h3000 + 4 * k) begin
                bad++; $display("[TB] FAIL full_order_%0d got %h want %h", k, store_address_o, 32'h3000 + 4 * k);
            end
            step(1'b0, '0, 1'b1);
        end
        repeat (4) begin
            step(1'b0, '0, 1'b0);
            total++; if (store_request_o !== 1'b0) begin bad++; $display("[TB] FAIL full_no_fifth got %b want 0", store_request_o); end
        end
        total++; if (empty_o !== 1'b1) begin bad++; $display("[TB] FAIL full_drained got %b want 1", empty_o); end
    endtask

    task automatic test_push_pop_full();
        for (int k = 0; k < 4; k++) step(1'b1, mk(32'h200 + k, 32'h5000 + 4 * k, 2'd2), 1'b0);
        wait_req("push_pop_full");
        step(1'b1, mk(32'h2FF, 32'h50F0, 2'd2), 1'b1);
        total++; if (full_o !== 1'b0) begin bad++; $display("[TB] FAIL ppf_not_full got %b want 0", full_o); end
        total++; if (empty_o !== 1'b0) begin bad++; $display("[TB] FAIL ppf_not_empty got %b want 0", empty_o); end
        step(1'b1, mk(32'h2AA, 32'h5100, 2'd2), 1'b0);
        total++; if (full_o !== 1'b1) begin bad++; $display("[TB] FAIL ppf_count3 got full=%b want 1", full_o); end
        drain_all();
        total++; if (empty_o !== 1'b1) begin bad++; $display("[TB] FAIL ppf_drained got %b want 1", empty_o); end
    endtask

    task automatic test_forwarding();
        step(1'b1, mk(32'h11, 32'h2000, 2'd2), 1'b0);
        step(1'b1, mk(32'h22, 32'h2000, 2'd2), 1'b0);
        fwd_address_i = 32'h2000;
        #1;
        total++; if (fwd_hit_o !== 1'b1) begin bad++; $display("[TB] FAIL fwd_hit got %b want 1", fwd_hit_o); end
        total++; if (fwd_data_o !== 32'h22) begin bad++; $display("[TB] FAIL fwd_data got %h want 00000022", fwd_data_o); end
        total++; if (fwd_conflict_o !== 1'b0) begin bad++; $display("[TB] FAIL fwd_noconf got %b want 0", fwd_conflict_o); end
        step(1'b1, mk(32'h33, 32'h2001, 2'd0), 1'b0);
        total++; if (fwd_conflict_o !== 1'b1) begin bad++; $display("[TB] FAIL fwd_conf got %b want 1", fwd_conflict_o); end
        total++; if (fwd_hit_o !== 1'b0) begin bad++; $display("[TB] FAIL fwd_conf_nohit got %b want 0", fwd_hit_o); end
        fwd_address_i = 32'h3000;
        #1;
        total++; if ({fwd_hit_o, fwd_conflict_o, fwd_data_o} !== 34'h0) begin
            bad++; $display("[TB] FAIL fwd_miss got hit=%b conf=%b data=%h want 0", fwd_hit_o, fwd_conflict_o, fwd_data_o);
        end
        drain_all();
    endtask

    task automatic test_reset_mid_request();
        for (int k = 0; k < 3; k++) step(1'b1, mk(32'h700 + k, 32'h7000 + 4 * k, 2'd2), 1'b0);
        wait_req("reset_mid");
        rst_n_i = 1'b0;
        #1;
        mq.delete();
        m_req = 1'b0;
        total++; if (store_request_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_req got %b want 0", store_request_o); end
        total++; if (empty_o !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_empty got %b want 1", empty_o); end
        #2;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        repeat (4) begin
            step(1'b0, '0, 1'b0);
            total++; if (store_request_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_quiet got %b want 0", store_request_o); end
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, mk(32'hA000 + k, 32'h4000 + 4 * k, 2'd2), 1'b0);
            wait_req("wrap");
            total++; if ({store_data_o, store_address_o} !== {32'hA000 + k, 32'h4000 + 4 * k}) begin
                bad++; $display("[TB] FAIL wrap_%0d got %h/%h want %h/%h", k, store_data_o, store_address_o,
                                32'hA000 + k, 32'h4000 + 4 * k);
            end
            step(1'b0, '0, 1'b1);
            total++; if (empty_o !== 1'b1) begin bad++; $display("[TB] FAIL wrap_empty_%0d got %b want 1", k, empty_o); end
        end
    endtask

    task automatic test_random();
        bit          hit, conf, push, done;
        logic [31:0] data;
        logic [65:0] pkt;
        for (int n = 0; n < 400; n++) begin
            push = ($urandom_range(0, 99) < 60);
            done = ($urandom_range(0, 99) < 45);
            pkt = mk($urandom, addr_set[$urandom_range(0, 4)], 2'($urandom_range(0, 2)));
            step(push, pkt, done);
            fwd_address_i = fwd_set[$urandom_range(0, 4)];
            #1;
            fwd_ref(fwd_address_i, hit, data, conf);
            total++; if (full_o !== (mq.size() == DEPTH)) begin
                bad++; $display("[TB] FAIL rnd_full cyc %0d got %b want %b", n, full_o, mq.size() == DEPTH);
            end
            total++; if (empty_o !== (mq.size() == 0)) begin
                bad++; $display("[TB] FAIL rnd_empty cyc %0d got %b want %b", n, empty_o, mq.size() == 0);
            end
            total++; if (store_request_o !== m_req) begin
                bad++; $display("[TB] FAIL rnd_req cyc %0d got %b want %b", n, store_request_o, m_req);
            end
            if (m_req) begin
                total++; if ({store_data_o, store_address_o, store_width_o} !== m_cur) begin
                    bad++; $display("[TB] FAIL rnd_payload cyc %0d got %h want %h", n,
                                    {store_data_o, store_address_o, store_width_o}, m_cur);
                end
            end
            total++; if ({fwd_hit_o, fwd_conflict_o, fwd_data_o} !== {hit, conf, data}) begin
                bad++; $display("[TB] FAIL rnd_fwd cyc %0d addr %h got hit=%b conf=%b data=%h want hit=%b conf=%b data=%h",
                                n, fwd_address_i, fwd_hit_o, fwd_conflict_o, fwd_data_o, hit, conf, data);
            end
        end
    endtask

    initial begin
        $display("[TB] store_buffer bench start");
        test_reset();
        test_single_store();
        test_full_order();
        test_push_pop_full();
        test_forwarding();
        test_reset_mid_request();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 4: number of entries; power of two, at least 2.
REQ-002 SHALL have port clk_i  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port push_request_i  in  1  store unit requests to write packet_i.
REQ-005 SHALL have port packet_i  in  66  {data[31:0], address[31:0], width[1:0]}; width encoding: 0 = byte, 1 = half, 2 = word.
REQ-006 SHALL have port full_o  out  1  buffer holds BUFFER_DEPTH entries.
REQ-007 SHALL have port empty_o  out  1  buffer holds no entries.
REQ-008 SHALL have port store_request_o  out  1  store request to the memory controller.
REQ-009 SHALL have ports store_data_o  out  32, store_address_o  out  32, store_width_o  out  2: payload of the head entry.
REQ-010 SHALL have port store_done_i  in  1  memory controller has completed the requested store.
REQ-011 SHALL have port fwd_address_i  in  32  load address for the forwarding lookup.
REQ-012 SHALL have port fwd_hit_o  out  1  forwarding data is valid.
REQ-013 SHALL have port fwd_data_o  out  32  forwarded word.
REQ-014 SHALL have port fwd_conflict_o  out  1  the load overlaps a pending store that cannot be forwarded.

Function
REQ-015 SHALL implement a circular FIFO with write pointer, read pointer and occupancy count of log2(BUFFER_DEPTH)+1 bits; both pointers wrap modulo BUFFER_DEPTH.
REQ-016 SHALL accept a push when push_request_i=1 and full_o=0, writing packet_i at the write pointer on that edge.
REQ-017 SHALL ignore push_request_i while full_o=1, even if a pop occurs in the same cycle; full_o depends on the registered count only.
REQ-018 SHALL drive full_o = (count == BUFFER_DEPTH) and empty_o = (count == 0), decoded combinationally from registered state.
REQ-019 SHALL leave count unchanged on a simultaneous accepted push and pop; the pointers still advance.
REQ-020 SHALL implement a drain FSM with two states: IDLE and REQUEST.
REQ-021 In IDLE with empty_o=0, SHALL register the head entry into the store_*_o registers, set store_request_o=1 and move to REQUEST.
REQ-022 In REQUEST, SHALL hold store_request_o=1 and keep store_*_o stable until store_done_i=1.
REQ-023 In REQUEST on store_done_i=1, SHALL pop the head (read pointer +1, count -1), clear store_request_o on that edge and return to IDLE.
REQ-024 SHALL ignore store_done_i while in IDLE.
REQ-025 Latency: a push accepted at edge N into an empty buffer SHALL give store_request_o=1 from edge N+1; back-to-back drains have one IDLE cycle between requests.
REQ-026 SHALL treat every entry from the read pointer up to the write pointer as valid, including the entry being drained, until it is popped.
REQ-027 Forwarding SHALL be combinational on fwd_address_i.
REQ-028 fwd_hit_o SHALL be 1 when any valid entry has width=word and address == fwd_address_i; fwd_data_o SHALL be the data of the youngest such entry, and 0 when there is no hit.
REQ-029 fwd_conflict_o SHALL be 1 when any valid entry has address[31:2] == fwd_address_i[31:2] and is not an exact word match.
REQ-030 When both a hit and a conflict are present, the youngest overlapping entry SHALL decide: a word match gives hit only, otherwise conflict only.

Reset
REQ-031 Asserting rst_n_i=0 SHALL immediately clear the pointers and count and set the FSM to IDLE: full_o=0, empty_o=1, store_request_o=0, store_data_o=0, store_address_o=0, store_width_o=0, fwd_hit_o=0, fwd_conflict_o=0.
REQ-032 Reset during REQUEST SHALL drop store_request_o immediately and discard all pending entries; entry storage need not be cleared.

Verification
REQ-033 Reset, then push {0xDEADBEEF, 0x1000, word} -> store_request_o=1 one cycle later with address 0x1000 and data 0xDEADBEEF; store_done_i held 3 cycles later -> empty_o=1 and store_request_o=0 after the done edge.
REQ-034 Push 4 entries with store_done_i=0 -> full_o=1; a 5th push is dropped; the drain order is 1,2,3,4 and no 5th request appears.
REQ-035 Buffer full, push_request_i and store_done_i in the same cycle -> push rejected, count goes to 3, full_o=0 next cycle.
REQ-036 Pushes of {0x11, 0x2000, word} then {0x22, 0x2000, word}, with fwd_address_i=0x2000 -> fwd_hit_o=1, fwd_data_o=0x22; a byte store to 0x2001 pending, with fwd_address_i=0x2000 -> fwd_conflict_o=1, fwd_hit_o=0.
REQ-037 Reset asserted mid-REQUEST with 3 entries pending -> store_request_o=0 and empty_o=1 immediately; no request after reset is released.
REQ-038 Run 10 push/drain cycles past pointer wrap -> data order is preserved and count never exceeds 4.
